// File: rtl/data_memory_responder.sv
// MEM-stage load/store responder: one request at a time on a 256-byte big-endian
// data memory, answered after WAIT_CYCLES wait states.
module data_memory_responder #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              error_q, error_d;

  logic [7:0]        mem [DEPTH];

  logic              commit;
  logic              c_write, c_size;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic              misaligned;
  logic              mem_we;
  logic [ADDR_W-1:0] a0, a1, a2, a3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      size_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // With zero wait states the commit uses the live request inputs, not the latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    commit  = 1'b0;
    c_write = write_q;
    c_size  = size_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            c_write = req_write;
            c_size  = req_size;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            state_d = ST_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    misaligned = c_size && (c_addr[1:0] != 2'b00);
    a0 = {c_addr[ADDR_W-1:2], 2'b00};
    a1 = {c_addr[ADDR_W-1:2], 2'b01};
    a2 = {c_addr[ADDR_W-1:2], 2'b10};
    a3 = {c_addr[ADDR_W-1:2], 2'b11};
    mem_we = commit && c_write && !misaligned;

    if (commit) begin
      error_d = misaligned;
      rdata_d = '0;
      if (!misaligned && !c_write) begin
        if (c_size) rdata_d = {mem[a0], mem[a1], mem[a2], mem[a3]};
        else        rdata_d = {24'b0, mem[c_addr]};
      end
    end
  end

  // Memory contents survive reset; a reset edge never commits.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      if (c_size) begin
        mem[a0] <= c_wdata[31:24];
        mem[a1] <= c_wdata[23:16];
        mem[a2] <= c_wdata[15:8];
        mem[a3] <= c_wdata[7:0];
      end else begin
        mem[c_addr] <= c_wdata[7:0];
      end
    end
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    busy       = (state_q != ST_IDLE);
  end

  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0
// instance share stimulus; sel picks which one is driven and observed.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_size = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b1;

  logic        rr2, rv2, re2, b2, rr0, rv0, re0, b0;
  logic [31:0] rd2, rd0;
  logic        m_ready, m_valid, m_err, m_busy;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rr2),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv2), .resp_ready(resp_ready), .resp_rdata(rd2), .resp_error(re2), .busy(b2));

  data_memory_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rr0),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_ready(resp_ready), .resp_rdata(rd0), .resp_error(re0), .busy(b0));

  assign m_ready = sel ? rr0 : rr2;
  assign m_valid = sel ? rv0 : rv2;
  assign m_rdata = sel ? rd0 : rd2;
  assign m_err   = sel ? re0 : re2;
  assign m_busy  = sel ? b0  : b2;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   pass_cnt = 0;
  int   total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: latency is the edge where resp_valid first appears minus the accepting edge.
  logic        prev_v = 1'b0;
  int unsigned rise = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (m_valid && !prev_v) rise = cyc;
      if (m_valid && resp_ready) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_resp: got response 0x%08h, expected none", m_rdata);
        end else begin
          e_m = sb.pop_front();
          chk("resp_rdata", m_rdata, e_m.rdata);
          chk("resp_error", {31'b0, m_err}, {31'b0, e_m.err});
          chk("latency", rise - e_m.acc, e_m.lat);
        end
      end
      prev_v = m_valid;
    end
  end

  // The accepting edge counts as the first of the WAIT_CYCLES+1 edges.
  task automatic issue(input logic w, input logic s, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input bit push);
    int unsigned n = 0;
    while (!m_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (!m_ready) begin
      total++;
      $display("FAIL ready_timeout: req_ready=0, expected 1");
    end
    req_valid = 1'b1; req_write = w; req_size = s; req_addr = a; req_wdata = d;
    @(posedge clk); #2;
    req_valid = 1'b0;
    if (push) sb.push_back('{er, ee, cyc, (sel ? 0 : 2)});
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (!(sb.size() == 0 && !m_valid) && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    if (!(sb.size() == 0 && !m_valid)) begin
      total++;
      $display("FAIL resp_timeout: pending=%0d resp_valid=%0b, expected 0 and 0", sb.size(), m_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_req_ready", {31'b0, m_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_busy", {31'b0, m_busy}, 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    chk("rst0_req_ready", {31'b0, rr0}, 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;

    // Word store / load
    issue(1, 1, 8'h10, 32'hDEADBEEF, 32'h0, 0, 1); wait_idle();
    issue(0, 1, 8'h10, 32'h0, 32'hDEADBEEF, 0, 1); wait_idle();
    // Byte loads, byte store, merged word load
    issue(0, 0, 8'h10, 32'h0, 32'h000000DE, 0, 1); wait_idle();
    issue(0, 0, 8'h13, 32'h0, 32'h000000EF, 0, 1); wait_idle();
    issue(1, 0, 8'h11, 32'h123456A5, 32'h0, 0, 1); wait_idle();
    issue(0, 1, 8'h10, 32'h0, 32'hDEA5BEEF, 0, 1); wait_idle();
    // Misaligned accesses
    issue(1, 1, 8'h20, 32'h01020304, 32'h0, 0, 1); wait_idle();
    issue(1, 1, 8'h22, 32'hFFFFFFFF, 32'h0, 1, 1); wait_idle();
    issue(0, 1, 8'h20, 32'h0, 32'h01020304, 0, 1); wait_idle();
    issue(0, 1, 8'h21, 32'h0, 32'h0, 1, 1); wait_idle();

    // Back-pressure in RESP; a request offered meanwhile must be ignored
    resp_ready = 1'b0;
    issue(0, 1, 8'h10, 32'h0, 32'hDEA5BEEF, 0, 1);
    for (int i = 0; i < 20 && !m_valid; i++) begin
      @(posedge clk); #2;
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_addr = 8'h10; req_wdata = '0;
      end
      if (i == 3) req_valid = 1'b0;
      chk("hold_valid", {31'b0, m_valid}, 32'd1);
      chk("hold_rdata", m_rdata, 32'hDEA5BEEF);
      chk("hold_busy", {31'b0, m_busy}, 32'd1);
      chk("hold_req_ready", {31'b0, m_ready}, 32'd0);
      @(posedge clk); #2;
    end
    resp_ready = 1'b1;
    @(posedge clk); #2;
    chk("release_valid", {31'b0, m_valid}, 32'd0);
    chk("release_req_ready", {31'b0, m_ready}, 32'd1);
    wait_idle();
    issue(0, 1, 8'h10, 32'h0, 32'hDEA5BEEF, 0, 1); wait_idle();

    // Reset during WAIT discards the pending store
    issue(1, 1, 8'h40, 32'hCAFEF00D, 32'h0, 0, 1); wait_idle();
    issue(0, 1, 8'h40, 32'h0, 32'hCAFEF00D, 0, 1); wait_idle();
    issue(1, 1, 8'h40, 32'h11223344, 32'h0, 0, 0);
    chk("wait_busy", {31'b0, m_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_req_ready", {31'b0, m_ready}, 32'd1);
    chk("mid_rst_resp_valid", {31'b0, m_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, m_busy}, 32'd0);
    chk("mid_rst_rdata", m_rdata, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
    end
    chk("post_rst_valid", {31'b0, m_valid}, 32'd0);
    issue(0, 1, 8'h40, 32'h0, 32'hCAFEF00D, 0, 1); wait_idle();

    // Zero-wait instance, top byte address
    sel = 1'b1;
    @(posedge clk); #2;
    issue(1, 0, 8'hFF, 32'hABCDEF7F, 32'h0, 0, 1); wait_idle();
    issue(0, 0, 8'hFF, 32'h0, 32'h0000007F, 0, 1); wait_idle();

    if (sb.size() != 0) begin
      total++;
      $display("FAIL leftover: %0d responses outstanding, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
